bitstream_window_ctrl: RTL and testbench

//  Sequences one evaluation window of a stochastic (bitstream) activation datapath.

---
 rtl/bitstream_window_ctrl_pkg.sv | 24 ++
 rtl/bitstream_window_ctrl_ones.sv | 31 +++
 rtl/bitstream_window_ctrl.sv | 131 +++++++++++++
 tb/tb_bitstream_window_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bitstream_window_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_pkg
//  Description : Shared window-controller state type and default window sizing
//                used by the bitstream activation datapath and layer sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package bitstream_pkg;

  // One evaluation window walks IDLE -> CLEAR -> FLUSH -> COUNT -> DONE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FLUSH = 3'd2,
    COUNT = 3'd3,
    DONE  = 3'd4
  } win_state_t;

  // Default bitstream length and datapath latency (1 reg + 5-tap buffer).
  localparam int DEF_WINDOW = 256;
  localparam int DEF_FLUSH  = 6;

endpackage
`default_nettype wire

// File: rtl/bitstream_window_ctrl_ones.sv
`default_nettype none
// ============================================================================
//  Module      : bs_ones_counter
//  Description : Counts ones on a bitstream while enabled; synchronous clear
//                has priority over counting.
//  Revision    : 1.0  initial release
// ============================================================================
module bs_ones_counter #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          bit_in,
  output logic [CW-1:0] count
);

  // Ones accumulator: clear wins, otherwise add one per high bit while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && bit_in) begin
      count <= count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bitstream_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_window_ctrl
//  Description : Sequences one evaluation window of a stochastic activation
//                datapath: reseed, flush latency, count ones over WINDOW
//                cycles, then hand the count out over valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
module bitstream_window_ctrl
  import bitstream_pkg::win_state_t;
#(
  parameter int WINDOW = 256,
  parameter int FLUSH  = 6,
  parameter int CW     = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          bit_in,
  output logic          dp_clr,
  output logic          dp_en,
  output logic          busy,
  output logic [CW-1:0] result,
  output logic          result_valid,
  input  logic          result_ready
);

  // Phase counter spans the longer of the two timed phases.
  localparam int PMAX = (FLUSH > WINDOW) ? FLUSH : WINDOW;
  localparam int PW   = $clog2(PMAX + 1);
  localparam logic [PW-1:0] WIN_LOAD   = PW'(WINDOW - 1);
  localparam logic [PW-1:0] FLUSH_LOAD = PW'((FLUSH > 0) ? (FLUSH - 1) : 0);

  win_state_t    state;
  logic [PW-1:0] phase;
  logic [CW-1:0] ones;
  logic          cnt_clr;
  logic          cnt_en;

  // Counter only runs in COUNT; it is held clear elsewhere so it starts from 0
  // on COUNT entry, and abort clears it even on the aborting edge.
  assign cnt_clr = (state != bitstream_pkg::COUNT) || abort;
  assign cnt_en  = (state == bitstream_pkg::COUNT);

  bs_ones_counter #(
    .CW (CW)
  ) u_ones (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .bit_in (bit_in),
    .count  (ones)
  );

  // Window FSM with registered outputs, phase counter and result handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= bitstream_pkg::IDLE;
      phase        <= '0;
      dp_clr       <= 1'b0;
      dp_en        <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      dp_clr <= 1'b0;
      if (abort && (state != bitstream_pkg::IDLE)) begin
        state        <= bitstream_pkg::IDLE;
        phase        <= '0;
        dp_en        <= 1'b0;
        busy         <= 1'b0;
        result_valid <= 1'b0;
      end else begin
        case (state)
          bitstream_pkg::IDLE: begin
            if (start) begin
              state  <= bitstream_pkg::CLEAR;
              dp_clr <= 1'b1;
              busy   <= 1'b1;
            end
          end
          bitstream_pkg::CLEAR: begin
            dp_en <= 1'b1;
            if (FLUSH == 0) begin
              state <= bitstream_pkg::COUNT;
              phase <= WIN_LOAD;
            end else begin
              state <= bitstream_pkg::FLUSH;
              phase <= FLUSH_LOAD;
            end
          end
          bitstream_pkg::FLUSH: begin
            if (phase == '0) begin
              state <= bitstream_pkg::COUNT;
              phase <= WIN_LOAD;
            end else begin
              phase <= phase - PW'(1);
            end
          end
          bitstream_pkg::COUNT: begin
            if (phase == '0) begin
              // The last COUNT-cycle bit is not yet in the counter.
              state        <= bitstream_pkg::DONE;
              result       <= ones + CW'(bit_in);
              result_valid <= 1'b1;
              dp_en        <= 1'b0;
            end else begin
              phase <= phase - PW'(1);
            end
          end
          bitstream_pkg::DONE: begin
            if (result_ready) begin
              state        <= bitstream_pkg::IDLE;
              result_valid <= 1'b0;
              busy         <= 1'b0;
            end
          end
          default: begin
            state <= bitstream_pkg::IDLE;
            dp_en <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitstream_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitstream_window_ctrl
//  Description : Self-checking bench for bitstream_window_ctrl with three
//                configurations sharing clock, reset and inputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bitstream_window_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic bit_in = 1'b0;
  logic result_ready = 1'b0;

  // instance 0: W=16 F=6, instance 1: W=256 F=6, instance 2: W=1 F=0
  logic clr_a, en_a, busy_a, val_a;
  logic clr_b, en_b, busy_b, val_b;
  logic clr_c, en_c, busy_c, val_c;
  logic [4:0] res_a;
  logic [8:0] res_b;
  logic [0:0] res_c;

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int last_res [3] = '{0, 0, 0};
  logic [3:0] lfsr;

  logic        o_clr, o_en, o_busy, o_val;
  logic [31:0] o_res;

  always #5 clk = ~clk;

  bitstream_window_ctrl #(.WINDOW(16), .FLUSH(6)) u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bit_in(bit_in),
    .dp_clr(clr_a), .dp_en(en_a), .busy(busy_a), .result(res_a),
    .result_valid(val_a), .result_ready(result_ready));

  bitstream_window_ctrl #(.WINDOW(bitstream_pkg::DEF_WINDOW), .FLUSH(bitstream_pkg::DEF_FLUSH)) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bit_in(bit_in),
    .dp_clr(clr_b), .dp_en(en_b), .busy(busy_b), .result(res_b),
    .result_valid(val_b), .result_ready(result_ready));

  bitstream_window_ctrl #(.WINDOW(1), .FLUSH(0)) u_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bit_in(bit_in),
    .dp_clr(clr_c), .dp_en(en_c), .busy(busy_c), .result(res_c),
    .result_valid(val_c), .result_ready(result_ready));

  // Route the instance under test to a common set of observation signals.
  always_comb begin
    o_clr = clr_a; o_en = en_a; o_busy = busy_a; o_val = val_a; o_res = 32'(res_a);
    if (sel == 1) begin
      o_clr = clr_b; o_en = en_b; o_busy = busy_b; o_val = val_b; o_res = 32'(res_b);
    end else if (sel == 2) begin
      o_clr = clr_c; o_en = en_c; o_busy = busy_c; o_val = val_c; o_res = 32'(res_c);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d): got %0d expected %0d at %0t", tag, sel, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: constant 1, mode 1: 4-bit LFSR compared <9, mode 2: $urandom
  function automatic logic next_bit(input int mode);
    logic b;
    if (mode == 0) begin
      b = 1'b1;
    end else if (mode == 1) begin
      b = (lfsr < 4'd9);
      lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end else begin
      b = 1'($urandom_range(0, 1));
    end
    return b;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; abort = 1'b0; result_ready = 1'b0; bit_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) last_res[i] = 0;
  endtask

  // One full window. Cycle k counts from the start-sampling edge: k=1 CLEAR,
  // k=2..1+F FLUSH, k=2+F..1+F+W COUNT, k=2+F+W first DONE cycle.
  task automatic run_window(input int fl, input int wn, input int mode,
                            input int hold, input bit start_in_done);
    int exp_sum;
    exp_sum = 0;
    start = 1'b1;
    result_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 1 + fl + wn; k++) begin
      bit_in = next_bit(mode);
      if (k >= 2 + fl) exp_sum += int'(bit_in);
      check("dp_clr", 32'(o_clr), 32'(k == 1));
      check("dp_en", 32'(o_en), 32'(k >= 2));
      check("busy_run", 32'(o_busy), 32'd1);
      check("valid_early", 32'(o_val), 32'd0);
      tick();
    end
    bit_in = 1'b0;
    check("valid_rise", 32'(o_val), 32'd1);
    check("result", o_res, 32'(exp_sum));
    check("dp_en_done", 32'(o_en), 32'd0);
    for (int h = 0; h < hold; h++) begin
      start = start_in_done && (h == hold / 2);
      tick();
      check("valid_hold", 32'(o_val), 32'd1);
      check("result_hold", o_res, 32'(exp_sum));
      check("busy_hold", 32'(o_busy), 32'd1);
    end
    start = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("valid_drop", 32'(o_val), 32'd0);
    check("busy_idle", 32'(o_busy), 32'd0);
    check("result_kept", o_res, 32'(exp_sum));
    tick();
    check("start_not_queued", 32'(o_busy), 32'd0);
    last_res[sel] = exp_sum;
  endtask

  initial begin
    #3;
    // Reset state for every configuration.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_clr", 32'(o_clr), 32'd0);
      check("rst_en", 32'(o_en), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_valid", 32'(o_val), 32'd0);
      check("rst_result", o_res, 32'd0);
    end
    do_reset();

    // Constant ones on the short window; 20-cycle stall with start during DONE.
    sel = 0;
    run_window(6, 16, 0, 0, 1'b0);
    run_window(6, 16, 0, 20, 1'b1);

    // Abort with start at the 5th COUNT cycle: no result, previous result held.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 2 + 6 + 4; k++) tick();
    check("abort_pre_busy", 32'(o_busy), 32'd1);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_idle", 32'(o_busy), 32'd0);
    check("abort_en", 32'(o_en), 32'd0);
    check("abort_valid", 32'(o_val), 32'd0);
    check("abort_result", o_res, 32'(last_res[0]));
    for (int k = 0; k < 24; k++) begin
      tick();
      check("abort_no_valid", 32'(o_val), 32'd0);
    end
    check("abort_still_idle", 32'(o_busy), 32'd0);

    // Abort in IDLE has no effect; ready without valid ignored.
    abort = 1'b1;
    result_ready = 1'b1;
    tick();
    abort = 1'b0;
    result_ready = 1'b0;
    check("idle_abort", 32'(o_busy), 32'd0);

    // Asynchronous reset in the middle of FLUSH.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_clr", 32'(o_clr), 32'd0);
    check("arst_en", 32'(o_en), 32'd0);
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_valid", 32'(o_val), 32'd0);
    check("arst_result", o_res, 32'd0);
    tick();
    rst = 1'b0;
    run_window(6, 16, 2, 3, 1'b0);

    // Random windows on the short configuration.
    for (int n = 0; n < 12; n++) begin
      run_window(6, 16, 2, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    // Full-length window with LFSR stream, ready effectively immediate.
    do_reset();
    sel = 1;
    lfsr = 4'b0010;
    run_window(6, 256, 1, 0, 1'b0);
    run_window(6, 256, 2, 2, 1'b1);

    // Degenerate window: no flush, one COUNT cycle.
    do_reset();
    sel = 2;
    run_window(0, 1, 0, 0, 1'b0);
    for (int n = 0; n < 8; n++) begin
      run_window(0, 1, 2, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
